// File: rtl/multi_issue_ctrl_if.sv
// Bundle-in / control-out handshake bundle between fetch buffer, issue stage and EX.
interface multi_issue_ctrl_if #(
  parameter int LANES = 2,
  parameter int OPW   = 7,
  parameter int REGW  = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*OPW-1:0]    opcode;
  logic [LANES*REGW-1:0]   rs1;
  logic [LANES*REGW-1:0]   rs2;
  logic [LANES*REGW-1:0]   rd;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        lane_vld;
  logic [LANES*8-1:0]      ctrl;

  // environment side: drives the bundle and the EX accept
  modport master (
    output in_valid, opcode, rs1, rs2, rd, out_ready,
    input  in_ready, out_valid, lane_vld, ctrl
  );

  // issue stage side
  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, out_ready,
    output in_ready, out_valid, lane_vld, ctrl
  );
endinterface

// File: rtl/multi_issue_ctrl.sv
// N-lane decode/issue control stage: per-lane RV32 opcode decode, load-use interlock,
// intra-bundle dependency splitting, flush and saturating stall accounting.
module multi_issue_ctrl #(
  parameter int LANES = 2,
  parameter int OPW   = 7,
  parameter int REGW  = 5,
  parameter int SCW   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  multi_issue_ctrl_if.slave     bus,
  output logic [SCW-1:0]        stall_cnt
);
  localparam int SW = $clog2(LANES + 1);

  localparam logic [OPW-1:0] OP_LD = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_ST = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_R  = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_I  = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_B  = OPW'(7'b1100011);

  // ctrl bit order: {branch, aluop[1:0], regwrite, alusrc, memwrite, memtoreg, memread}
  localparam int C_RW = 4;
  localparam int C_MR = 0;

  logic [SW-1:0]                    r_base;
  logic                             r_out_valid;
  logic [LANES-1:0]                 r_lane_vld;
  logic [LANES-1:0][7:0]            r_ctrl;
  logic [LANES-1:0][REGW-1:0]       r_rd;
  logic [SCW-1:0]                   r_stall;

  logic [LANES-1:0][OPW-1:0]        w_op;
  logic [LANES-1:0][REGW-1:0]       w_rs1, w_rs2, w_rd;
  logic [LANES-1:0][7:0]            w_dec;
  logic [LANES-1:0]                 w_use1, w_use2;
  logic                             w_haz;
  logic [SW-1:0]                    w_split;
  logic                             w_found, w_dep;
  logic                             w_adv;
  logic                             w_in_ready;

  assign w_op  = bus.opcode;
  assign w_rs1 = bus.rs1;
  assign w_rs2 = bus.rs2;
  assign w_rd  = bus.rd;

  // per-lane decode into control word and source-operand usage
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_dec[l]  = 8'h00;
      w_use1[l] = 1'b0;
      w_use2[l] = 1'b0;
      case (w_op[l])
        OP_LD: begin w_dec[l] = 8'b0_00_1_1_0_1_1; w_use1[l] = 1'b1; end
        OP_ST: begin w_dec[l] = 8'b0_00_0_1_1_0_0; w_use1[l] = 1'b1; w_use2[l] = 1'b1; end
        OP_R:  begin w_dec[l] = 8'b0_10_1_0_0_0_0; w_use1[l] = 1'b1; w_use2[l] = 1'b1; end
        OP_I:  begin w_dec[l] = 8'b0_11_1_1_0_0_0; w_use1[l] = 1'b1; end
        OP_B:  begin w_dec[l] = 8'b1_01_0_0_0_0_0; w_use1[l] = 1'b1; w_use2[l] = 1'b1; end
        default: ;
      endcase
    end
  end

  // load-use: an issued load's rd is read by any lane still waiting (index >= base)
  always_comb begin
    w_haz = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (r_out_valid && r_lane_vld[l] && r_ctrl[l][C_MR] && r_rd[l] != '0) begin
        for (int p = 0; p < LANES; p++) begin
          if (p >= int'(r_base) &&
              ((w_use1[p] && w_rs1[p] == r_rd[l]) || (w_use2[p] && w_rs2[p] == r_rd[l])))
            w_haz = 1'b1;
        end
      end
    end
  end

  // split point: first lane above base that reads an rd written earlier in the same issue group
  always_comb begin
    w_split = SW'(LANES);
    w_found = 1'b0;
    w_dep   = 1'b0;
    for (int j = 1; j < LANES; j++) begin
      w_dep = 1'b0;
      for (int k = 0; k < j; k++) begin
        if (k >= int'(r_base) && w_dec[k][C_RW] && w_rd[k] != '0 &&
            ((w_use1[j] && w_rs1[j] == w_rd[k]) || (w_use2[j] && w_rs2[j] == w_rd[k])))
          w_dep = 1'b1;
      end
      if (!w_found && j > int'(r_base) && w_dep) begin
        w_found = 1'b1;
        w_split = SW'(j);
      end
    end
  end

  assign w_adv      = !r_out_valid || bus.out_ready;
  // bundle retires only when its last group issues; held low in reset and on flush
  assign w_in_ready = rst_n && !flush && w_adv && !w_haz && bus.in_valid &&
                      (w_split == SW'(LANES));

  // ID/EX control register and resume point within the current bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_out_valid <= 1'b0;
      r_lane_vld  <= '0;
      r_ctrl      <= '0;
      r_rd        <= '0;
    end else if (flush) begin
      r_base      <= '0;
      r_out_valid <= 1'b0;
      r_lane_vld  <= '0;
      r_ctrl      <= '0;
      r_rd        <= '0;
    end else if (w_adv) begin
      if (!w_haz && bus.in_valid) begin
        r_out_valid <= 1'b1;
        for (int l = 0; l < LANES; l++) begin
          if (l >= int'(r_base) && l < int'(w_split)) begin
            r_lane_vld[l] <= 1'b1;
            r_ctrl[l]     <= w_dec[l];
            r_rd[l]       <= w_rd[l];
          end else begin
            r_lane_vld[l] <= 1'b0;
            r_ctrl[l]     <= 8'h00;
            r_rd[l]       <= '0;
          end
        end
        r_base <= (w_split == SW'(LANES)) ? '0 : w_split;
      end else begin
        // bubble: either interlocked (base kept) or nothing to issue
        r_out_valid <= 1'b0;
        r_lane_vld  <= '0;
        r_ctrl      <= '0;
        r_rd        <= '0;
      end
    end
  end

  // saturating count of cycles a valid bundle was held back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (bus.in_valid && !w_in_ready && !flush && !(&r_stall))
      r_stall <= r_stall + 1'b1;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.lane_vld  = r_lane_vld;
  assign bus.ctrl      = r_ctrl;
  assign stall_cnt     = r_stall;
endmodule

// File: tb/tb_multi_issue_ctrl.sv
// Directed bench for multi_issue_ctrl (LANES=2): decode, split, load-use, backpressure,
// flush, stall saturation and asynchronous reset.
module tb_multi_issue_ctrl;
  localparam int LANES = 2;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;

  // expected control words {branch,aluop,regwrite,alusrc,memwrite,memtoreg,memread}
  localparam logic [7:0] C_LD = 8'h1B;
  localparam logic [7:0] C_ST = 8'h0C;
  localparam logic [7:0] C_R  = 8'h50;
  localparam logic [7:0] C_I  = 8'h78;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  int          tot = 0;
  int          bad = 0;

  multi_issue_ctrl_if #(.LANES(LANES), .OPW(7), .REGW(5)) bus ();

  multi_issue_ctrl #(.LANES(LANES), .OPW(7), .REGW(5), .SCW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic lane(input int l, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2);
    bus.opcode[l*7 +: 7] = op;
    bus.rd[l*5 +: 5]     = d;
    bus.rs1[l*5 +: 5]    = s1;
    bus.rs2[l*5 +: 5]    = s2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.rd        = '0;
    #1;
    chk("rst_ovld",  bus.out_valid, 0);
    chk("rst_lvld",  bus.lane_vld, 0);
    chk("rst_ctrl",  bus.ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_irdy",  bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    // 1: independent R + I dual issue
    lane(0, RT, 5'd6, 5'd1, 5'd2);
    lane(1, IT, 5'd5, 5'd3, 5'd0);
    bus.in_valid = 1'b1;
    #1 chk("t1_irdy", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk("t1_ovld",  bus.out_valid, 1);
    chk("t1_lvld",  bus.lane_vld, 2'b11);
    chk("t1_ctrl",  bus.ctrl, {C_I, C_R});
    chk("t1_stall", stall_cnt, 0);

    // 2: RAW inside bundle splits into two issue cycles
    lane(0, IT, 5'd5, 5'd3, 5'd0);
    lane(1, RT, 5'd6, 5'd5, 5'd1);
    bus.in_valid = 1'b1;
    #1 chk("t2_irdy0", bus.in_ready, 0);
    tick;
    chk("t2_lvld0", bus.lane_vld, 2'b01);
    chk("t2_ctrl0", bus.ctrl, {8'h00, C_I});
    chk("t2_irdy1", bus.in_ready, 1);
    tick;
    chk("t2_lvld1", bus.lane_vld, 2'b10);
    chk("t2_ctrl1", bus.ctrl, {C_R, 8'h00});
    chk("t2_stall", stall_cnt, 1);
    // x0 never creates a dependency
    lane(0, IT, 5'd0, 5'd3, 5'd0);
    lane(1, RT, 5'd6, 5'd0, 5'd1);
    #1 chk("t2_x0_irdy", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk("t2_x0_lvld",  bus.lane_vld, 2'b11);
    chk("t2_x0_stall", stall_cnt, 1);

    // 3: load followed by a consumer -> one bubble
    lane(0, LD, 5'd7, 5'd1, 5'd0);
    lane(1, IT, 5'd0, 5'd0, 5'd0);
    bus.in_valid = 1'b1;
    #1 chk("t3_ld_irdy", bus.in_ready, 1);
    tick;
    chk("t3_ld_ctrl", bus.ctrl, {C_I, C_LD});
    lane(0, IT, 5'd1, 5'd2, 5'd0);
    lane(1, ST, 5'd0, 5'd2, 5'd7);
    #1 chk("t3_haz_irdy", bus.in_ready, 0);
    tick;
    chk("t3_bub_ovld", bus.out_valid, 0);
    chk("t3_bub_lvld", bus.lane_vld, 2'b00);
    chk("t3_bub_ctrl", bus.ctrl, 0);
    #1 chk("t3_irdy", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk("t3_lvld",  bus.lane_vld, 2'b11);
    chk("t3_ctrl",  bus.ctrl, {C_ST, C_I});
    chk("t3_stall", stall_cnt, 2);

    // 4: EX backpressure holds the register
    lane(0, RT, 5'd3, 5'd1, 5'd2);
    lane(1, RT, 5'd4, 5'd1, 5'd2);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1 chk("t4_irdy", bus.in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("t4_hold_lvld", bus.lane_vld, 2'b11);
      chk("t4_hold_ctrl", bus.ctrl, {C_ST, C_I});
      chk("t4_hold_stall", stall_cnt, 32'(3 + c));
    end
    bus.out_ready = 1'b1;
    #1 chk("t4_rel_irdy", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk("t4_rel_ctrl", bus.ctrl, {C_R, C_R});

    // 5: flush during second half of a split
    lane(0, IT, 5'd5, 5'd3, 5'd0);
    lane(1, RT, 5'd6, 5'd5, 5'd1);
    bus.in_valid = 1'b1;
    tick;
    chk("t5_lvld0", bus.lane_vld, 2'b01);
    flush = 1'b1;
    #1 chk("t5_fl_irdy", bus.in_ready, 0);
    tick;
    flush = 1'b0;
    chk("t5_fl_ovld",  bus.out_valid, 0);
    chk("t5_fl_lvld",  bus.lane_vld, 0);
    chk("t5_fl_stall", stall_cnt, 6);
    lane(0, RT, 5'd3, 5'd1, 5'd2);
    lane(1, IT, 5'd4, 5'd1, 5'd0);
    #1 chk("t5_nx_irdy", bus.in_ready, 1);
    tick;
    chk("t5_nx_lvld", bus.lane_vld, 2'b11);
    chk("t5_nx_ctrl", bus.ctrl, {C_I, C_R});

    // 6: saturate the stall counter, then reset mid-split
    bus.out_ready = 1'b0;
    repeat (65600) @(posedge clk);
    #1 chk("t6_sat", stall_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1 chk("t6_sat_hold", stall_cnt, 16'hFFFF);
    bus.out_ready = 1'b1;
    lane(0, IT, 5'd5, 5'd3, 5'd0);
    lane(1, RT, 5'd6, 5'd5, 5'd1);
    tick;
    chk("t6_split_lvld", bus.lane_vld, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ovld",  bus.out_valid, 0);
    chk("t6_rst_lvld",  bus.lane_vld, 0);
    chk("t6_rst_ctrl",  bus.ctrl, 0);
    chk("t6_rst_stall", stall_cnt, 0);
    chk("t6_rst_irdy",  bus.in_ready, 0);
    #2 rst_n = 1'b1;
    tick;
    chk("t6_restart_lvld", bus.lane_vld, 2'b01);
    bus.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
